// File: rtl/crypto_op_sequencer_if.sv
// Core <-> crypto op sequencer bus.
//   op_e        : level op enables from core (bit index = op id)
//   op_done     : per-op done, 1 = op not stalling core
//   stall/busy  : aggregate stall term and FSM-not-idle flag
//   grant_id    : id of op in service (0 when idle)
//   err_multi/err_abort : sticky error flags
//   op_count/busy_cycles: perf counters
interface crypto_op_sequencer_if #(
    parameter int unsigned NOPS = 21,
    parameter int unsigned GW   = 5
);
    logic [NOPS-1:0] op_e;
    logic [NOPS-1:0] op_done;
    logic            stall;
    logic            busy;
    logic [GW-1:0]   grant_id;
    logic            err_multi;
    logic            err_abort;
    logic [15:0]     op_count;
    logic [31:0]     busy_cycles;

    modport master (
        output op_e,
        input  op_done, stall, busy, grant_id, err_multi, err_abort, op_count, busy_cycles
    );

    modport slave (
        input  op_e,
        output op_done, stall, busy, grant_id, err_multi, err_abort, op_count, busy_cycles
    );
endinterface

// File: rtl/crypto_op_sequencer.sv
// Serialises AES / IMCRYPTO coprocessor ops, inserts a per-group wait-state
// count, returns per-op done strobes and the aggregate stall term for halt.
//   clk : core clock
//   res : asynchronous active-high reset
//   bus : slave side of crypto_op_sequencer_if (op_e in, status/counters out)
module crypto_op_sequencer #(
    parameter int unsigned NOPS    = 21,
    parameter int unsigned NAES    = 10,
    parameter int unsigned LAT_AES = 1,
    parameter int unsigned LAT_IM  = 1,
    parameter int unsigned GW      = 5
) (
    input  logic                  clk,
    input  logic                  res,
    crypto_op_sequencer_if.slave  bus
);
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] LAT_AES_L = CW'(LAT_AES);
    localparam logic [CW-1:0] LAT_IM_L  = CW'(LAT_IM);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gid_q, gid_d;
    logic            err_multi_q, err_multi_d;
    logic            err_abort_q, err_abort_d;
    logic [15:0]     op_count_q, op_count_d;
    logic [31:0]     busy_cycles_q, busy_cycles_d;

    logic [NOPS-1:0] op_done_c;
    logic            stall_c;
    logic [GW-1:0]   low_id_c;
    logic [CW-1:0]   lat_c;

    // Per-op done: idle ops never stall; the granted op is released in DONE.
    always_comb begin
        op_done_c = '1;
        for (int i = 0; i < int'(NOPS); i++) begin
            op_done_c[i] = ~bus.op_e[i] | ((state_q == S_DONE) && (gid_q == GW'(i)));
        end
    end

    assign stall_c = ~&op_done_c;

    // Lowest set enable wins arbitration.
    always_comb begin
        low_id_c = '0;
        for (int i = int'(NOPS) - 1; i >= 0; i--) begin
            if (bus.op_e[i]) begin
                low_id_c = GW'(i);
            end
        end
    end

    assign lat_c = (low_id_c < GW'(NAES)) ? LAT_AES_L : LAT_IM_L;

    // State register and sticky/perf registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            gid_q         <= '0;
            err_multi_q   <= 1'b0;
            err_abort_q   <= 1'b0;
            op_count_q    <= '0;
            busy_cycles_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gid_q         <= gid_d;
            err_multi_q   <= err_multi_d;
            err_abort_q   <= err_abort_d;
            op_count_q    <= op_count_d;
            busy_cycles_q <= busy_cycles_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gid_d         = gid_q;
        err_multi_d   = err_multi_q;
        err_abort_d   = err_abort_q;
        op_count_d    = op_count_q;
        busy_cycles_d = (stall_c && (busy_cycles_q != '1)) ? busy_cycles_q + 32'd1 : busy_cycles_q;

        case (state_q)
            S_IDLE: begin
                if (|bus.op_e) begin
                    gid_d = low_id_c;
                    if ($countones(bus.op_e) > 1) begin
                        err_multi_d = 1'b1;
                    end
                    // The grant cycle itself is stall cycle 1, so BUSY waits lat-2 more.
                    if (lat_c <= CW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = lat_c - CW'(2);
                    end
                end
            end
            S_BUSY: begin
                if (!bus.op_e[gid_q]) begin
                    err_abort_d = 1'b1;
                    state_d     = S_IDLE;
                    gid_d       = '0;
                    cnt_d       = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                op_count_d = op_count_q + 16'd1;
                state_d    = S_IDLE;
                gid_d      = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.op_done     = op_done_c;
    assign bus.stall       = stall_c;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.grant_id    = gid_q;
    assign bus.err_multi   = err_multi_q;
    assign bus.err_abort   = err_abort_q;
    assign bus.op_count    = op_count_q;
    assign bus.busy_cycles = busy_cycles_q;
endmodule

// File: tb/tb_crypto_op_sequencer.sv
// Directed bench: three sequencer instances with different latency settings.
//   dut_a : LAT_AES=1, LAT_IM=4
//   dut_b : LAT_AES=2, LAT_IM=2
//   dut_c : LAT_AES=3, LAT_IM=1
module tb_crypto_op_sequencer;
    localparam int unsigned NOPS = 21;
    localparam int unsigned GW   = 5;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    crypto_op_sequencer_if #(.NOPS(NOPS), .GW(GW)) ifa ();
    crypto_op_sequencer_if #(.NOPS(NOPS), .GW(GW)) ifb ();
    crypto_op_sequencer_if #(.NOPS(NOPS), .GW(GW)) ifc ();

    crypto_op_sequencer #(.NOPS(NOPS), .NAES(10), .LAT_AES(1), .LAT_IM(4), .GW(GW))
        dut_a (.clk(clk), .res(res), .bus(ifa.slave));
    crypto_op_sequencer #(.NOPS(NOPS), .NAES(10), .LAT_AES(2), .LAT_IM(2), .GW(GW))
        dut_b (.clk(clk), .res(res), .bus(ifb.slave));
    crypto_op_sequencer #(.NOPS(NOPS), .NAES(10), .LAT_AES(3), .LAT_IM(1), .GW(GW))
        dut_c (.clk(clk), .res(res), .bus(ifc.slave));

    function automatic logic [NOPS-1:0] bit_of(input int i);
        logic [NOPS-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        ifa.op_e = '0;
        ifb.op_e = '0;
        ifc.op_e = '0;
        res = 1'b1;
        #3;
        res = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", ifa.busy); end
        n_cmp++; if (ifa.op_done !== {NOPS{1'b1}}) begin n_err++; $display("FAIL reset_op_done got %0h want %0h", ifa.op_done, {NOPS{1'b1}}); end
        n_cmp++; if (ifa.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b want 0", ifa.stall); end
        n_cmp++; if (ifa.grant_id !== 5'd0) begin n_err++; $display("FAIL reset_grant got %0d want 0", ifa.grant_id); end
        n_cmp++; if (ifa.op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count got %0d want 0", ifa.op_count); end
        n_cmp++; if (ifa.busy_cycles !== 32'd0) begin n_err++; $display("FAIL reset_busy_cycles got %0d want 0", ifa.busy_cycles); end
        n_cmp++; if ({ifa.err_multi, ifa.err_abort} !== 2'b00) begin n_err++; $display("FAIL reset_err got %0b want 00", {ifa.err_multi, ifa.err_abort}); end
    endtask

    task automatic test_single_aes();
        do_reset();
        ifa.op_e = bit_of(2);
        #1;
        n_cmp++; if (ifa.stall !== 1'b1) begin n_err++; $display("FAIL aes_c0_stall got %0b want 1", ifa.stall); end
        n_cmp++; if (ifa.op_done[2] !== 1'b0) begin n_err++; $display("FAIL aes_c0_done got %0b want 0", ifa.op_done[2]); end
        tick();
        n_cmp++; if (ifa.op_done[2] !== 1'b1) begin n_err++; $display("FAIL aes_c1_done got %0b want 1", ifa.op_done[2]); end
        n_cmp++; if (ifa.stall !== 1'b0) begin n_err++; $display("FAIL aes_c1_stall got %0b want 0", ifa.stall); end
        n_cmp++; if (ifa.grant_id !== 5'd2) begin n_err++; $display("FAIL aes_c1_grant got %0d want 2", ifa.grant_id); end
        tick();
        ifa.op_e = '0;
        #1;
        n_cmp++; if (ifa.op_count !== 16'd1) begin n_err++; $display("FAIL aes_op_count got %0d want 1", ifa.op_count); end
        n_cmp++; if (ifa.busy_cycles !== 32'd1) begin n_err++; $display("FAIL aes_busy_cycles got %0d want 1", ifa.busy_cycles); end
        n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL aes_c2_busy got %0b want 0", ifa.busy); end
    endtask

    task automatic test_im_latency();
        do_reset();
        ifa.op_e = bit_of(12);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (ifa.op_done[12] !== 1'b0) begin n_err++; $display("FAIL im_wait_c%0d got %0b want 0", k, ifa.op_done[12]); end
            tick();
        end
        n_cmp++; if (ifa.op_done[12] !== 1'b1) begin n_err++; $display("FAIL im_c4_done got %0b want 1", ifa.op_done[12]); end
        n_cmp++; if (ifa.stall !== 1'b0) begin n_err++; $display("FAIL im_c4_stall got %0b want 0", ifa.stall); end
        tick();
        ifa.op_e = '0;
        #1;
        n_cmp++; if (ifa.busy_cycles !== 32'd4) begin n_err++; $display("FAIL im_busy_cycles got %0d want 4", ifa.busy_cycles); end
        n_cmp++; if (ifa.op_count !== 16'd1) begin n_err++; $display("FAIL im_op_count got %0d want 1", ifa.op_count); end
    endtask

    task automatic test_multi();
        do_reset();
        ifb.op_e = bit_of(3) | bit_of(15);
        #1;
        n_cmp++; if (ifb.stall !== 1'b1) begin n_err++; $display("FAIL multi_c0_stall got %0b want 1", ifb.stall); end
        tick();
        n_cmp++; if (ifb.op_done[3] !== 1'b0) begin n_err++; $display("FAIL multi_c1_done3 got %0b want 0", ifb.op_done[3]); end
        n_cmp++; if (ifb.err_multi !== 1'b1) begin n_err++; $display("FAIL multi_err got %0b want 1", ifb.err_multi); end
        tick();
        n_cmp++; if (ifb.op_done[3] !== 1'b1) begin n_err++; $display("FAIL multi_c2_done3 got %0b want 1", ifb.op_done[3]); end
        n_cmp++; if (ifb.stall !== 1'b1) begin n_err++; $display("FAIL multi_c2_stall got %0b want 1", ifb.stall); end
        n_cmp++; if (ifb.op_done[15] !== 1'b0) begin n_err++; $display("FAIL multi_c2_done15 got %0b want 0", ifb.op_done[15]); end
        tick();
        ifb.op_e = bit_of(15);
        #1;
        n_cmp++; if (ifb.busy !== 1'b0) begin n_err++; $display("FAIL multi_c3_busy got %0b want 0", ifb.busy); end
        tick();
        n_cmp++; if (ifb.grant_id !== 5'd15) begin n_err++; $display("FAIL multi_c4_grant got %0d want 15", ifb.grant_id); end
        n_cmp++; if (ifb.op_done[15] !== 1'b0) begin n_err++; $display("FAIL multi_c4_done15 got %0b want 0", ifb.op_done[15]); end
        tick();
        n_cmp++; if (ifb.op_done[15] !== 1'b1) begin n_err++; $display("FAIL multi_c5_done15 got %0b want 1", ifb.op_done[15]); end
        tick();
        ifb.op_e = '0;
        #1;
        n_cmp++; if (ifb.op_count !== 16'd2) begin n_err++; $display("FAIL multi_op_count got %0d want 2", ifb.op_count); end
        n_cmp++; if (ifb.busy_cycles !== 32'd5) begin n_err++; $display("FAIL multi_busy_cycles got %0d want 5", ifb.busy_cycles); end
        n_cmp++; if (ifb.err_multi !== 1'b1) begin n_err++; $display("FAIL multi_err_sticky got %0b want 1", ifb.err_multi); end
    endtask

    task automatic test_abort();
        do_reset();
        ifc.op_e = bit_of(0);
        tick();
        n_cmp++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL abort_c1_busy got %0b want 1", ifc.busy); end
        ifc.op_e = '0;
        tick();
        n_cmp++; if (ifc.err_abort !== 1'b1) begin n_err++; $display("FAIL abort_err got %0b want 1", ifc.err_abort); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL abort_c2_busy got %0b want 0", ifc.busy); end
        n_cmp++; if (ifc.grant_id !== 5'd0) begin n_err++; $display("FAIL abort_grant got %0d want 0", ifc.grant_id); end
        tick();
        n_cmp++; if (ifc.op_count !== 16'd0) begin n_err++; $display("FAIL abort_op_count got %0d want 0", ifc.op_count); end
        n_cmp++; if (ifc.err_multi !== 1'b0) begin n_err++; $display("FAIL abort_err_multi got %0b want 0", ifc.err_multi); end
    endtask

    task automatic test_async_reset();
        do_reset();
        ifa.op_e = bit_of(12) | bit_of(13);
        tick();
        tick();
        n_cmp++; if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL ares_pre_busy got %0b want 1", ifa.busy); end
        n_cmp++; if (ifa.busy_cycles !== 32'd2) begin n_err++; $display("FAIL ares_pre_cycles got %0d want 2", ifa.busy_cycles); end
        n_cmp++; if (ifa.err_multi !== 1'b1) begin n_err++; $display("FAIL ares_pre_err got %0b want 1", ifa.err_multi); end
        #1;
        res = 1'b1;
        #1;
        n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL ares_busy got %0b want 0", ifa.busy); end
        n_cmp++; if (ifa.busy_cycles !== 32'd0) begin n_err++; $display("FAIL ares_cycles got %0d want 0", ifa.busy_cycles); end
        n_cmp++; if (ifa.err_multi !== 1'b0) begin n_err++; $display("FAIL ares_err got %0b want 0", ifa.err_multi); end
        n_cmp++; if (ifa.grant_id !== 5'd0) begin n_err++; $display("FAIL ares_grant got %0d want 0", ifa.grant_id); end
        ifa.op_e = '0;
        res = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] seen;
        logic [3:0] want;
        do_reset();
        want = 4'b1010;
        seen = '0;
        ifa.op_e = bit_of(5);
        #1;
        for (int k = 0; k < 4; k++) begin
            seen[k] = ifa.op_done[5];
            tick();
        end
        ifa.op_e = '0;
        #1;
        n_cmp++; if (seen !== want) begin n_err++; $display("FAIL b2b_pulses got %b want %b", seen, want); end
        n_cmp++; if (ifa.op_count !== 16'd2) begin n_err++; $display("FAIL b2b_op_count got %0d want 2", ifa.op_count); end
        n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy got %0b want 0", ifa.busy); end
        tick();
        n_cmp++; if (ifa.op_count !== 16'd2) begin n_err++; $display("FAIL b2b_no_retrigger got %0d want 2", ifa.op_count); end
    endtask

    initial begin
        ifa.op_e = '0;
        ifb.op_e = '0;
        ifc.op_e = '0;
        test_reset();
        test_single_aes();
        test_im_latency();
        test_multi();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
